// File: rtl/rsram_pkg.sv
// ---------------------------------------------------------------------------
// rsram_pkg
// Shared definitions for the rsram line-buffer scheduler and its read address
// generator: bank count, one-hot FSM state encodings and the mod-3 bank step.
// ---------------------------------------------------------------------------
package rsram_pkg;

    localparam int RSRAM_BANKS = 3;

    // One-hot scheduler state encodings
    localparam logic [6:0] S_IDLE  = 7'b000_0001;
    localparam logic [6:0] S_FILL  = 7'b000_0010;
    localparam logic [6:0] S_START = 7'b000_0100;
    localparam logic [6:0] S_RUN   = 7'b000_1000;
    localparam logic [6:0] S_WAIT  = 7'b001_0000;
    localparam logic [6:0] S_ADV   = 7'b010_0000;
    localparam logic [6:0] S_DONE  = 7'b100_0000;

    typedef enum logic [6:0] {
        ST_IDLE  = S_IDLE,
        ST_FILL  = S_FILL,
        ST_START = S_START,
        ST_RUN   = S_RUN,
        ST_WAIT  = S_WAIT,
        ST_ADV   = S_ADV,
        ST_DONE  = S_DONE
    } sched_state_t;

    // Bank index step 0 -> 1 -> 2 -> 0; same encoding as the generator's bank select
    function automatic logic [1:0] next_bank(input logic [1:0] bank);
        return (bank == 2'd2) ? 2'd0 : bank + 2'd1;
    endfunction

endpackage

// File: rtl/rsram_bank_sched_if.sv
// ---------------------------------------------------------------------------
// rsram_bank_sched_if
// Bundles the scheduler's pixel stream, rsram write bus and read-generator
// handshake.
//   wr_valid/wr_ready/wr_last       : upstream pixel stream
//   wsram_we/wsram_bank/wsram_addr  : rsram write port
//   genaddr_start/bank_ok/banksel   : control to the read address generator
//   pass_done                       : generator finished the current bank pair
// modport master : the scheduler
// modport slave  : upstream source, rsram and generator side
// ---------------------------------------------------------------------------
interface rsram_bank_sched_if #(
    parameter int LINE_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_last;
    logic              wsram_we;
    logic [1:0]        wsram_bank;
    logic [LINE_W-1:0] wsram_addr;
    logic              genaddr_start;
    logic              bank_ok;
    logic [1:0]        banksel;
    logic              pass_done;

    modport master (
        input  wr_valid, wr_last, pass_done,
        output wr_ready, wsram_we, wsram_bank, wsram_addr,
        output genaddr_start, bank_ok, banksel
    );

    modport slave (
        output wr_valid, wr_last, pass_done,
        input  wr_ready, wsram_we, wsram_bank, wsram_addr,
        input  genaddr_start, bank_ok, banksel
    );
endinterface

// File: rtl/rsram_wr_ctrl.sv
// ---------------------------------------------------------------------------
// rsram_wr_ctrl
// Write side of the three-bank line buffer. Accepts pixels while the target
// bank is empty and the picture still has lines outstanding; addresses the
// rsram combinationally from the accept, and pulses the full-set bit of the
// bank that just received its last pixel.
// Ports:
//   SYS_CLK, SYS_RST : clock, synchronous active-high reset
//   clear            : start of a new picture, zeroes all counters
//   active           : scheduler is in a write-capable state
//   pic_size         : lines in the picture
//   full             : per-bank full flags owned by the scheduler
//   wr_valid/wr_last : upstream pixel qualifiers
//   wr_ready         : pixel can be accepted this cycle
//   wsram_*          : rsram write enable, bank and pixel address
//   full_set         : one-hot bank that completed a line this cycle
// ---------------------------------------------------------------------------
module rsram_wr_ctrl
    import rsram_pkg::*;
#(
    parameter int LINE_W = 8,
    parameter int PIC_W  = 8
) (
    input  logic                   SYS_CLK,
    input  logic                   SYS_RST,
    input  logic                   clear,
    input  logic                   active,
    input  logic [PIC_W-1:0]       pic_size,
    input  logic [RSRAM_BANKS-1:0] full,
    input  logic                   wr_valid,
    input  logic                   wr_last,
    output logic                   wr_ready,
    output logic                   wsram_we,
    output logic [1:0]             wsram_bank,
    output logic [LINE_W-1:0]      wsram_addr,
    output logic [RSRAM_BANKS-1:0] full_set
);
    logic [1:0]        wbank;
    logic [LINE_W-1:0] pix_cnt;
    logic [PIC_W-1:0]  lines_wr;
    logic [3:0]        full_ext;
    logic              accept;

    // Pad to a power of two so the 2-bit bank index never selects out of range
    assign full_ext = {1'b0, full};

    assign wr_ready   = active && !full_ext[wbank] && (lines_wr < pic_size);
    assign accept     = wr_valid && wr_ready;
    assign wsram_we   = accept;
    assign wsram_bank = wbank;
    assign wsram_addr = pix_cnt;
    assign full_set   = (accept && wr_last) ? (RSRAM_BANKS'(1) << wbank) : '0;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST || clear) begin
            wbank    <= 2'd0;
            pix_cnt  <= '0;
            lines_wr <= '0;
        end else if (accept) begin
            if (wr_last) begin
                pix_cnt  <= '0;
                wbank    <= next_bank(wbank);
                lines_wr <= lines_wr + 1'b1;
            end else begin
                pix_cnt  <= pix_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rsram_bank_sched.sv
// ---------------------------------------------------------------------------
// rsram_bank_sched
// Three-bank line-buffer scheduler for the CNN read SRAM. One picture line is
// written per bank; the read generator is started once banks 0/1 are full and
// is then advanced through pairs 0/1 -> 1/2 -> 2/0 as each pass completes and
// the next bank has been refilled.
// Ports:
//   SYS_CLK, SYS_RST : clock, synchronous active-high reset
//   cfg_start        : start pulse, honoured only in IDLE
//   cfg_pic_size     : lines in the picture, latched on cfg_start
//   bus              : pixel stream, rsram write port, generator handshake
//   busy             : scheduler not idle
//   done             : one-cycle picture-complete pulse
// ---------------------------------------------------------------------------
module rsram_bank_sched
    import rsram_pkg::*;
#(
    parameter int LINE_W = 8,
    parameter int PIC_W  = 8
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RST,
    input  logic             cfg_start,
    input  logic [PIC_W-1:0] cfg_pic_size,
    rsram_bank_sched_if.master bus,
    output logic             busy,
    output logic             done
);
    sched_state_t           state;
    logic [PIC_W-1:0]       pic_size;
    logic [PIC_W-1:0]       passes;
    logic [1:0]             rbank;
    logic [1:0]             wait_bank;
    logic [RSRAM_BANKS-1:0] full;
    logic [RSRAM_BANKS-1:0] full_nxt;
    logic [RSRAM_BANKS-1:0] full_set;
    logic [3:0]             full_ext;
    logic                   start_acc;
    logic                   pic_ok;
    logic                   wr_active;

    assign start_acc = (state == ST_IDLE) && cfg_start;
    // A picture under two lines has no bank pair to read, so nothing is written
    assign pic_ok    = (pic_size >= PIC_W'(2));
    assign wr_active = (state != ST_IDLE) && (state != ST_DONE) && pic_ok;
    // Bank that must be full before the pair can move on: the one after rbank+1
    assign wait_bank = next_bank(next_bank(rbank));
    assign full_ext  = {1'b0, full};

    rsram_wr_ctrl #(
        .LINE_W (LINE_W),
        .PIC_W  (PIC_W)
    ) u_wr_ctrl (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST    (SYS_RST),
        .clear      (start_acc),
        .active     (wr_active),
        .pic_size   (pic_size),
        .full       (full),
        .wr_valid   (bus.wr_valid),
        .wr_last    (bus.wr_last),
        .wr_ready   (bus.wr_ready),
        .wsram_we   (bus.wsram_we),
        .wsram_bank (bus.wsram_bank),
        .wsram_addr (bus.wsram_addr),
        .full_set   (full_set)
    );

    // Set from the writer and release by ADV can hit different banks in the
    // same cycle (wbank never equals rbank while reading), so both apply.
    always_comb begin
        full_nxt = full | full_set;
        if (state == ST_ADV) begin
            full_nxt = full_nxt & ~(RSRAM_BANKS'(1) << rbank);
        end
        if (state == ST_DONE || start_acc) begin
            full_nxt = '0;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state    <= ST_IDLE;
            full     <= '0;
            rbank    <= 2'd0;
            passes   <= '0;
            pic_size <= '0;
        end else begin
            full <= full_nxt;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        pic_size <= cfg_pic_size;
                        rbank    <= 2'd0;
                        passes   <= '0;
                        state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!pic_ok) begin
                        state <= ST_DONE;
                    end else if (full[0] && full[1]) begin
                        state <= ST_START;
                    end
                end
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (bus.pass_done) begin
                        passes <= passes + 1'b1;
                        // P lines give P-1 passes
                        if (passes + 1'b1 == pic_size - 1'b1) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (full_ext[wait_bank]) begin
                        state <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    rbank <= next_bank(rbank);
                    state <= ST_RUN;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode single flops of the one-hot state register
    assign bus.genaddr_start = (state == ST_START);
    assign bus.bank_ok       = (state == ST_ADV);
    assign bus.banksel       = rbank;
    assign busy              = (state != ST_IDLE);
    assign done              = (state == ST_DONE);
endmodule

// File: doc/rsram_bank_sched.md
# rsram_bank_sched

Three-bank line-buffer scheduler for the CNN read SRAM (rsram). It accepts one picture line per bank from the upstream pixel stream and drives the bank write enables and addresses. It issues `genaddr_start` and `bank_ok` to the rsram read address generator, so the generator always reads a fully written bank pair while the third bank is refilled. Bank pair rotation is 0/1, then 1/2, then 2/0, matching the generator's bank-select encoding 00→01→10→00.

## Interface
Parameters:
- `LINE_W`, default 8: width of the pixel-in-line address. A line holds at most 2^LINE_W pixels.
- `PIC_W`, default 8: width of the picture line count.

Ports:
- `SYS_CLK`, in, 1: system clock.
- `SYS_RST`, in, 1: synchronous, active-high reset.
- `cfg_start`, in, 1: single-cycle start pulse. Sampled only in IDLE.
- `cfg_pic_size`, in, PIC_W: number of lines in the picture. Latched on `cfg_start`.
- `wr_valid`, in, 1: pixel valid from upstream.
- `wr_ready`, out, 1: scheduler accepts a pixel.
- `wr_last`, in, 1: marks the final pixel of a line. Qualified by the handshake.
- `wsram_we`, out, 1: rsram write enable.
- `wsram_bank`, out, 2: bank being written, 0..2.
- `wsram_addr`, out, LINE_W: pixel index within the line.
- `genaddr_start`, out, 1: one-cycle start pulse to the read address generator.
- `bank_ok`, out, 1: one-cycle pulse that advances the generator's bank pair.
- `banksel`, out, 2: current read pair index. 0 means banks 0/1, 1 means 1/2, 2 means 2/0.
- `pass_done`, in, 1: generator has finished all windows on the current pair.
- `busy`, out, 1: high whenever the scheduler is not in IDLE.
- `done`, out, 1: one-cycle pulse when the picture is complete.

## Operation
- **State register:** one-hot, with states IDLE, FILL, START, RUN, WAIT, ADV, DONE.
- **Internal state:**
  - `full[2:0]`: per-bank full flags.
  - `wbank`: write bank index, range 0..2.
  - `rbank`: read bank index, range 0..2; drives `banksel`.
  - `pix_cnt`: LINE_W-bit pixel counter.
  - `lines_wr`: lines written.
  - `passes`: read passes completed.
- **IDLE:**
  - On `cfg_start`: latch `P = cfg_pic_size`; clear `full`, `wbank`, `rbank`, `pix_cnt`, `lines_wr` and `passes`; go to FILL.
  - If `P < 2`, go directly to DONE instead.
- **Write path (FILL, START, RUN, WAIT, ADV):**
  - `wr_ready = !full[wbank] && (lines_wr < P)`.
  - Pixel accept is `wr_valid && wr_ready`. It is combinational to the rsram:
    - `wsram_we = accept`
    - `wsram_bank = wbank`
    - `wsram_addr = pix_cnt`
  - On accept, `pix_cnt` increments and wraps modulo 2^LINE_W.
  - On accept with `wr_last`: set `full[wbank]`, advance `wbank` modulo 3, clear `pix_cnt`, increment `lines_wr`.
- **FILL:** go to START when `full[0] && full[1]`.
- **START:** assert `genaddr_start`, go to RUN.
- **RUN:** on `pass_done`, increment `passes`.
  - If `passes + 1 == P - 1`, go to DONE.
  - Otherwise go to WAIT.
- **WAIT:** go to ADV when `full[(rbank+2) mod 3]` is set. Stay in WAIT indefinitely otherwise.
- **ADV:** assert `bank_ok`, clear `full[rbank]`, advance `rbank` modulo 3, go to RUN.
- **DONE:** assert `done`, clear `full`, go to IDLE.
- **Ignored inputs:**
  - `pass_done` outside RUN.
  - `cfg_start` outside IDLE.
  - Pixels offered once `lines_wr == P` (`wr_ready` stays low).
- **Simultaneous events:**
  - `wr_last` in ADV sets `full[wbank]` in the same cycle that `full[rbank]` clears. `wbank != rbank` always holds while RUN, WAIT and ADV are active, so both updates apply.
  - `wr_last` in WAIT sets the flag that WAIT is testing. The transition to ADV happens on the following cycle.
- **Reset mid-operation:** everything returns to IDLE with all flags cleared, regardless of the outstanding generator pass.

## Timing
- **Reset values:** every output is 0, including `banksel = 0` and `busy = 0`.
- `wsram_*` outputs have zero latency from the accept.
- `genaddr_start` is high exactly 2 cycles after the clock edge that accepts the second `wr_last`: one cycle to FILL→START, then the pulse.
- `bank_ok` is high earliest 2 cycles after `pass_done` (RUN→WAIT, then WAIT→ADV). It is never high in the same cycle as `genaddr_start`.
- `banksel` updates on the cycle after the `bank_ok` pulse.
- `done` is high 1 cycle after the final `pass_done`. `busy` drops in the following cycle.
- A picture of P lines produces 1 `genaddr_start`, P−2 `bank_ok` pulses, and P−1 passes.

## Structure
- **Shared package `rsram_pkg`:**
  - state one-hot localparams
  - `RSRAM_BANKS = 3`
  - a `next_bank` mod-3 increment function, also usable by the address generator
- **Sub-module `rsram_wr_ctrl`:** the write path (`pix_cnt`, `wbank`, `lines_wr`, `full`-set pulse). The scheduler top keeps the FSM, `rbank` and `full` clear.

## Test plan
- **Basic flow, P=4, 8-pixel lines:**
  - Stimulus: write 4 lines; return `pass_done` 20 cycles after each `genaddr_start` or `bank_ok`.
  - Required: 1 `genaddr_start`, 2 `bank_ok`; `banksel` sequence 0,1,2; `done` after the 3rd `pass_done`.
  - Required: `wsram_bank` sequence 0,1,2,0 with `wsram_addr` running 0..7 on each line.
- **Writer slow:** P=3; issue `pass_done` before line 3 is written.
  - Required: the FSM holds in WAIT with `bank_ok` low until the cycle after `full[2]` sets.
- **Reader slow:**
  - Required: after banks 0, 1 and 2 fill, `wr_ready` stays 0 until `bank_ok` frees bank 0.
  - Required: the next line is written to bank 0.
- **Degenerate sizes:**
  - `cfg_pic_size = 1` → `done` 2 cycles after `cfg_start`, no `genaddr_start`, no writes.
  - `cfg_pic_size = 2` → one pass, 0 `bank_ok`.
- **Ignored events:** `cfg_start` while busy, and `pass_done` in FILL → no state change.
- **Mid-run reset:** assert `SYS_RST` during WAIT → all outputs 0 next cycle, then a fresh P=4 run passes.
